// File: rtl/data_bus_ctrl.sv
// Memory-mapped data-bus controller: decodes CPU load/store requests onto N
// windowed slaves, waits on slave ready with a bounded timeout, logs bus errors.
module data_bus_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int N_SLAVES   = 2,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE  = {32'd128, 32'd0},
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_LIMIT = {32'd130, 32'd127},
    parameter int TIMEOUT    = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           m_req,
    input  logic                           m_we,
    input  logic [ADDR_WIDTH-1:0]          m_addr,
    input  logic [DATA_WIDTH-1:0]          m_wdata,
    output logic [DATA_WIDTH-1:0]          m_rdata,
    output logic                           m_ready,
    output logic                           m_err,
    output logic [N_SLAVES-1:0]            s_sel,
    output logic                           s_we,
    output logic [ADDR_WIDTH-1:0]          s_addr,
    output logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]            s_ready,
    input  logic                           err_clr,
    output logic [ADDR_WIDTH-1:0]          err_addr,
    output logic [7:0]                     err_cnt,
    output logic [1:0]                     state_dbg
);

    // Master side: m_req is a level sampled only in IDLE and must stay stable
    // until the single-cycle m_ready strobe; m_err is meaningful only with m_ready.
    // Slave side: s_sel is one-hot and held until the selected s_ready is seen
    // at a clock edge or the timeout expires.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT);

    state_t                  state;
    logic [IW-1:0]           idx;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [TW-1:0]           cnt;

    logic                    hit;
    logic [IW-1:0]           hit_idx;
    logic [ADDR_WIDTH-1:0]   hit_off;
    logic                    sel_ready;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic [TW-1:0]           cnt_inc;
    logic                    timeout_hit;
    logic                    log_err;

    assign state_dbg = state;

    // Scan from the top index down so the lowest overlapping window wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_off = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (m_addr >= SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] &&
                m_addr <= SLAVE_LIMIT[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
                hit_off = m_addr - SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign sel_ready   = s_ready[idx];
    assign sel_rdata   = s_rdata[32'(idx)*DATA_WIDTH +: DATA_WIDTH];
    assign cnt_inc     = cnt + TW'(1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_VAL);
    // Ready beats a timeout landing on the same edge.
    assign log_err     = (state == IDLE && m_req && !hit) ||
                         (state == ACCESS && !sel_ready && timeout_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            req_addr <= '0;
            cnt      <= '0;
            s_sel    <= '0;
            s_we     <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            m_rdata  <= '0;
            m_ready  <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_req) begin
                        req_addr <= m_addr;
                        if (hit) begin
                            state   <= ACCESS;
                            idx     <= hit_idx;
                            s_sel   <= N_SLAVES'(1) << hit_idx;
                            s_we    <= m_we;
                            s_addr  <= hit_off;
                            s_wdata <= m_wdata;
                            cnt     <= '0;
                        end else begin
                            state   <= RESP;
                            m_ready <= 1'b1;
                            m_err   <= 1'b1;
                            m_rdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        state   <= RESP;
                        m_ready <= 1'b1;
                        if (!s_we) m_rdata <= sel_rdata;
                        s_sel   <= '0;
                        s_we    <= 1'b0;
                    end else if (timeout_hit) begin
                        state   <= RESP;
                        m_ready <= 1'b1;
                        m_err   <= 1'b1;
                        m_rdata <= '0;
                        s_sel   <= '0;
                        s_we    <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A new error on the same edge as err_clr restarts the log at one entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr <= '0;
            err_cnt  <= '0;
        end else if (log_err) begin
            err_addr <= (state == IDLE) ? m_addr : req_addr;
            if (err_clr)                err_cnt <= 8'd1;
            else if (err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
        end else if (err_clr) begin
            err_addr <= '0;
            err_cnt  <= '0;
        end
    end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Directed bench for data_bus_ctrl with default parameters: two slaves at
// [0,127] and [128,130], TIMEOUT=15.
module tb_data_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_req = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        m_err;
    logic [1:0]  s_sel;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [63:0] s_rdata = '0;
    logic [1:0]  s_ready = '0;
    logic        err_clr = 1'b0;
    logic [31:0] err_addr;
    logic [7:0]  err_cnt;
    logic [1:0]  state_dbg;

    int checks = 0;
    int failures = 0;

    data_bus_ctrl dut (
        .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
        .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready), .err_clr(err_clr),
        .err_addr(err_addr), .err_cnt(err_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick; tick;
        checks++; if (m_ready !== 1'b0) begin failures++; $display("FAIL rst_m_ready got=%0h exp=0", m_ready); end
        checks++; if (m_err !== 1'b0) begin failures++; $display("FAIL rst_m_err got=%0h exp=0", m_err); end
        checks++; if (m_rdata !== 32'h0) begin failures++; $display("FAIL rst_m_rdata got=%0h exp=0", m_rdata); end
        checks++; if (s_sel !== 2'b00) begin failures++; $display("FAIL rst_s_sel got=%0h exp=0", s_sel); end
        checks++; if (s_we !== 1'b0) begin failures++; $display("FAIL rst_s_we got=%0h exp=0", s_we); end
        checks++; if (s_addr !== 32'h0) begin failures++; $display("FAIL rst_s_addr got=%0h exp=0", s_addr); end
        checks++; if (s_wdata !== 32'h0) begin failures++; $display("FAIL rst_s_wdata got=%0h exp=0", s_wdata); end
        checks++; if (err_addr !== 32'h0) begin failures++; $display("FAIL rst_err_addr got=%0h exp=0", err_addr); end
        checks++; if (err_cnt !== 8'h0) begin failures++; $display("FAIL rst_err_cnt got=%0h exp=0", err_cnt); end
        checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL rst_state got=%0h exp=0", state_dbg); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_read_hit;
        m_addr = 32'h5; m_we = 1'b0; s_rdata = {32'h0, 32'hDEADBEEF}; s_ready = 2'b01; m_req = 1'b1;
        tick;
        checks++; if (s_sel !== 2'b01) begin failures++; $display("FAIL rd_s_sel got=%0h exp=1", s_sel); end
        checks++; if (s_addr !== 32'h5) begin failures++; $display("FAIL rd_s_addr got=%0h exp=5", s_addr); end
        checks++; if (s_we !== 1'b0) begin failures++; $display("FAIL rd_s_we got=%0h exp=0", s_we); end
        checks++; if (m_ready !== 1'b0) begin failures++; $display("FAIL rd_early_ready got=%0h exp=0", m_ready); end
        tick;
        checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL rd_m_ready got=%0h exp=1", m_ready); end
        checks++; if (m_err !== 1'b0) begin failures++; $display("FAIL rd_m_err got=%0h exp=0", m_err); end
        checks++; if (m_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_m_rdata got=%0h exp=deadbeef", m_rdata); end
        checks++; if (s_sel !== 2'b00) begin failures++; $display("FAIL rd_s_sel_drop got=%0h exp=0", s_sel); end
        tick;
        checks++; if (m_ready !== 1'b0) begin failures++; $display("FAIL rd_ready_one_cycle got=%0h exp=0", m_ready); end
        m_req = 1'b0; s_ready = 2'b00;
    endtask

    task automatic test_write_wait;
        // s_ready[0] is high but belongs to the unselected slave.
        m_addr = 32'h81; m_we = 1'b1; m_wdata = 32'hA5; s_ready = 2'b01; m_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (s_sel !== 2'b10) begin failures++; $display("FAIL wr_s_sel cyc=%0d got=%0h exp=2", i, s_sel); end
            checks++; if (s_we !== 1'b1) begin failures++; $display("FAIL wr_s_we cyc=%0d got=%0h exp=1", i, s_we); end
            checks++; if (s_addr !== 32'h1) begin failures++; $display("FAIL wr_s_addr cyc=%0d got=%0h exp=1", i, s_addr); end
            checks++; if (s_wdata !== 32'hA5) begin failures++; $display("FAIL wr_s_wdata cyc=%0d got=%0h exp=a5", i, s_wdata); end
            checks++; if (m_ready !== 1'b0) begin failures++; $display("FAIL wr_early_ready cyc=%0d got=%0h exp=0", i, m_ready); end
            if (i == 3) s_ready = 2'b10;
        end
        tick;
        checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL wr_m_ready got=%0h exp=1", m_ready); end
        checks++; if (m_err !== 1'b0) begin failures++; $display("FAIL wr_m_err got=%0h exp=0", m_err); end
        checks++; if (m_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rdata_held got=%0h exp=deadbeef", m_rdata); end
        checks++; if (s_sel !== 2'b00) begin failures++; $display("FAIL wr_s_sel_drop got=%0h exp=0", s_sel); end
        tick;
        m_req = 1'b0; m_we = 1'b0; s_ready = 2'b00;
    endtask

    task automatic test_miss;
        m_addr = 32'h200; m_req = 1'b1;
        tick;
        checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL miss_m_ready got=%0h exp=1", m_ready); end
        checks++; if (m_err !== 1'b1) begin failures++; $display("FAIL miss_m_err got=%0h exp=1", m_err); end
        checks++; if (m_rdata !== 32'h0) begin failures++; $display("FAIL miss_m_rdata got=%0h exp=0", m_rdata); end
        checks++; if (s_sel !== 2'b00) begin failures++; $display("FAIL miss_s_sel got=%0h exp=0", s_sel); end
        checks++; if (err_addr !== 32'h200) begin failures++; $display("FAIL miss_err_addr got=%0h exp=200", err_addr); end
        checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL miss_err_cnt got=%0d exp=1", err_cnt); end
        tick;
        checks++; if (m_ready !== 1'b0) begin failures++; $display("FAIL miss_ready_one_cycle got=%0h exp=0", m_ready); end
        m_req = 1'b0;
        tick;
        // One past slave 1's inclusive limit.
        m_addr = 32'h83; m_req = 1'b1;
        tick;
        checks++; if (m_err !== 1'b1) begin failures++; $display("FAIL miss83_m_err got=%0h exp=1", m_err); end
        checks++; if (err_addr !== 32'h83) begin failures++; $display("FAIL miss83_err_addr got=%0h exp=83", err_addr); end
        checks++; if (err_cnt !== 8'd2) begin failures++; $display("FAIL miss83_err_cnt got=%0d exp=2", err_cnt); end
        tick;
        m_req = 1'b0;
    endtask

    task automatic test_timeout;
        int sel_cycles = 0;
        bit seen = 1'b0;
        m_addr = 32'h10; s_ready = 2'b00; m_req = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick;
            if (s_sel === 2'b01) sel_cycles++;
            if (m_ready === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL to_no_ready got=0 exp=1"); end
        checks++; if (sel_cycles != 15) begin failures++; $display("FAIL to_sel_cycles got=%0d exp=15", sel_cycles); end
        checks++; if (m_err !== 1'b1) begin failures++; $display("FAIL to_m_err got=%0h exp=1", m_err); end
        checks++; if (m_rdata !== 32'h0) begin failures++; $display("FAIL to_m_rdata got=%0h exp=0", m_rdata); end
        checks++; if (err_cnt !== 8'd3) begin failures++; $display("FAIL to_err_cnt got=%0d exp=3", err_cnt); end
        checks++; if (err_addr !== 32'h10) begin failures++; $display("FAIL to_err_addr got=%0h exp=10", err_addr); end
        tick;
        m_req = 1'b0;
    endtask

    task automatic test_saturate;
        m_addr = 32'h10; s_ready = 2'b00;
        for (int n = 0; n < 300; n++) begin
            bit seen = 1'b0;
            m_req = 1'b1;
            for (int i = 0; i < 40 && !seen; i++) begin
                tick;
                if (m_ready === 1'b1) seen = 1'b1;
            end
            checks++; if (!seen) begin failures++; $display("FAIL sat_no_ready txn=%0d", n); end
            tick;
            m_req = 1'b0;
            if (n == 250) begin
                checks++; if (err_cnt !== 8'd254) begin failures++; $display("FAIL sat_err_cnt_254 got=%0d exp=254", err_cnt); end
            end
        end
        checks++; if (err_cnt !== 8'd255) begin failures++; $display("FAIL sat_err_cnt got=%0d exp=255", err_cnt); end
    endtask

    task automatic test_err_clr;
        m_addr = 32'h300; m_req = 1'b1; err_clr = 1'b1;
        tick;
        checks++; if (m_err !== 1'b1) begin failures++; $display("FAIL clr_m_err got=%0h exp=1", m_err); end
        checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL clr_coincide_cnt got=%0d exp=1", err_cnt); end
        checks++; if (err_addr !== 32'h300) begin failures++; $display("FAIL clr_coincide_addr got=%0h exp=300", err_addr); end
        err_clr = 1'b0;
        tick;
        m_req = 1'b0;
        tick;
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL clr_cnt got=%0d exp=0", err_cnt); end
        checks++; if (err_addr !== 32'h0) begin failures++; $display("FAIL clr_addr got=%0h exp=0", err_addr); end
    endtask

    task automatic test_ready_at_timeout;
        m_addr = 32'h10; s_rdata = {32'h0, 32'h12345678}; s_ready = 2'b00; m_req = 1'b1;
        repeat (15) tick;
        checks++; if (s_sel !== 2'b01) begin failures++; $display("FAIL rat_s_sel got=%0h exp=1", s_sel); end
        checks++; if (m_ready !== 1'b0) begin failures++; $display("FAIL rat_early_ready got=%0h exp=0", m_ready); end
        s_ready = 2'b01;
        tick;
        checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL rat_m_ready got=%0h exp=1", m_ready); end
        checks++; if (m_err !== 1'b0) begin failures++; $display("FAIL rat_m_err got=%0h exp=0", m_err); end
        checks++; if (m_rdata !== 32'h12345678) begin failures++; $display("FAIL rat_m_rdata got=%0h exp=12345678", m_rdata); end
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL rat_err_cnt got=%0d exp=0", err_cnt); end
        tick;
        m_req = 1'b0; s_ready = 2'b00;
    endtask

    task automatic test_reset_mid;
        int ready_seen = 0;
        m_addr = 32'h20; s_ready = 2'b00; m_req = 1'b1;
        tick; tick; tick;
        checks++; if (s_sel !== 2'b01) begin failures++; $display("FAIL rm_pre_s_sel got=%0h exp=1", s_sel); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL rm_state got=%0h exp=0", state_dbg); end
        checks++; if (s_sel !== 2'b00) begin failures++; $display("FAIL rm_s_sel got=%0h exp=0", s_sel); end
        checks++; if (s_addr !== 32'h0) begin failures++; $display("FAIL rm_s_addr got=%0h exp=0", s_addr); end
        checks++; if (m_rdata !== 32'h0) begin failures++; $display("FAIL rm_m_rdata got=%0h exp=0", m_rdata); end
        checks++; if (m_ready !== 1'b0) begin failures++; $display("FAIL rm_m_ready got=%0h exp=0", m_ready); end
        m_req = 1'b0;
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (m_ready !== 1'b0) ready_seen++;
        end
        checks++; if (ready_seen != 0) begin failures++; $display("FAIL rm_spurious_ready got=%0d exp=0", ready_seen); end
        // Slave 0's inclusive upper limit.
        m_addr = 32'h7F; s_rdata = {32'h0, 32'hCAFEF00D}; s_ready = 2'b01; m_req = 1'b1;
        tick;
        checks++; if (s_sel !== 2'b01) begin failures++; $display("FAIL rm_next_s_sel got=%0h exp=1", s_sel); end
        checks++; if (s_addr !== 32'h7F) begin failures++; $display("FAIL rm_next_s_addr got=%0h exp=7f", s_addr); end
        tick;
        checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL rm_next_ready got=%0h exp=1", m_ready); end
        checks++; if (m_err !== 1'b0) begin failures++; $display("FAIL rm_next_err got=%0h exp=0", m_err); end
        checks++; if (m_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL rm_next_rdata got=%0h exp=cafef00d", m_rdata); end
        tick;
        m_req = 1'b0; s_ready = 2'b00;
    endtask

    task automatic test_back_to_back;
        m_addr = 32'h82; m_we = 1'b0; s_rdata = {32'hBBBB0001, 32'h0}; s_ready = 2'b10; m_req = 1'b1;
        tick;
        checks++; if (s_sel !== 2'b10) begin failures++; $display("FAIL b2b_s_sel1 got=%0h exp=2", s_sel); end
        checks++; if (s_addr !== 32'h2) begin failures++; $display("FAIL b2b_s_addr got=%0h exp=2", s_addr); end
        tick;
        checks++; if (m_rdata !== 32'hBBBB0001) begin failures++; $display("FAIL b2b_rdata1 got=%0h exp=bbbb0001", m_rdata); end
        s_rdata = {32'hBBBB0002, 32'h0};
        tick;
        checks++; if (m_ready !== 1'b0) begin failures++; $display("FAIL b2b_gap_ready got=%0h exp=0", m_ready); end
        checks++; if (s_sel !== 2'b00) begin failures++; $display("FAIL b2b_gap_s_sel got=%0h exp=0", s_sel); end
        tick;
        checks++; if (s_sel !== 2'b10) begin failures++; $display("FAIL b2b_s_sel2 got=%0h exp=2", s_sel); end
        tick;
        checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready2 got=%0h exp=1", m_ready); end
        checks++; if (m_rdata !== 32'hBBBB0002) begin failures++; $display("FAIL b2b_rdata2 got=%0h exp=bbbb0002", m_rdata); end
        tick;
        m_req = 1'b0; s_ready = 2'b00;
    endtask

    initial begin
        test_reset;
        test_read_hit;
        test_write_wait;
        test_miss;
        test_timeout;
        test_saturate;
        test_err_clr;
        test_ready_at_timeout;
        test_reset_mid;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
